// File: rtl/muldiv_pkg.sv
// muldiv_pkg: shared types for the HI/LO multiply/divide sequencer.
//   muldiv_op_t    : 3-bit op code; bit2 = double (64-bit), bit1 = divide,
//                    bit0 = unsigned.
//   muldiv_state_t : sequencer states.
package muldiv_pkg;

    typedef enum logic [2:0] {
        MULT   = 3'd0,
        MULTU  = 3'd1,
        DIV    = 3'd2,
        DIVU   = 3'd3,
        DMULT  = 3'd4,
        DMULTU = 3'd5,
        DDIV   = 3'd6,
        DDIVU  = 3'd7
    } muldiv_op_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CALC  = 2'd1,
        FIXUP = 2'd2
    } muldiv_state_t;

endpackage

// File: rtl/muldiv_step.sv
// muldiv_step: one radix-2 iteration, purely combinational.
//   is_div  in  : 1 = restoring divide step, 0 = shift-add multiply step
//   acc_in  in  : current accumulator
//                 multiply: {partial product high, multiplier/product low}
//                 divide  : {partial remainder, dividend/quotient}
//   operand in  : multiplicand magnitude (multiply) or divisor magnitude
//   acc_out out : accumulator after this iteration
module muldiv_step #(
    parameter int unsigned XLEN = 64
) (
    input  logic              is_div,
    input  logic [2*XLEN-1:0] acc_in,
    input  logic [XLEN-1:0]   operand,
    output logic [2*XLEN-1:0] acc_out
);

    logic [XLEN:0]     sum;
    logic [XLEN:0]     diff;
    logic [2*XLEN-1:0] shl;

    always_comb begin
        sum  = {1'b0, acc_in[2*XLEN-1:XLEN]} + {1'b0, operand};
        shl  = {acc_in[2*XLEN-2:0], 1'b0};
        // The shifted partial remainder is XLEN+1 bits wide; a clear top bit
        // of the difference means it was >= divisor.
        diff = acc_in[2*XLEN-1:XLEN-1] - {1'b0, operand};
        if (is_div) begin
            if (!diff[XLEN]) begin
                acc_out = {diff[XLEN-1:0], shl[XLEN-1:1], 1'b1};
            end else begin
                acc_out = shl;
            end
        end else if (acc_in[0]) begin
            // Carry out of the add re-enters at the top on the right shift.
            acc_out = {sum, acc_in[XLEN-1:1]};
        end else begin
            acc_out = {1'b0, acc_in[2*XLEN-1:1]};
        end
    end

endmodule

// File: rtl/muldiv_ctrl.sv
// muldiv_ctrl: HI/LO multiply/divide sequencer beside the EX stage.
// Iterative radix-2 shift-add multiply and restoring divide on magnitudes,
// with sign fix-up in a final cycle. Owns architectural HI/LO.
// Optional build macro: MULDIV_FAST_MUL_EN - multiplies use a single-cycle
// multiplier and go IDLE -> FIXUP directly; divides still iterate.
// Ports:
//   clock, reset_n       : clock, asynchronous active-low reset
//   start, op, a, b      : EX-stage muldiv issue with forwarded operands
//   flush                : squash an issuing start / abort an in-flight op
//   hilo_read            : MFHI/MFLO in EX
//   mthi, mtlo, wdata    : MTHI/MTLO in EX and their data
//   hi, lo               : architectural HI/LO registers
//   busy                 : op in flight
//   stall                : hold IF/ID/EX this cycle
//   done                 : pulse in the cycle HI/LO are being written
module muldiv_ctrl
    import muldiv_pkg::*;
#(
    parameter int unsigned XLEN = 64,
    parameter int unsigned HALF = 32
) (
    input  logic            clock,
    input  logic            reset_n,
    input  logic            start,
    input  muldiv_op_t      op,
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    input  logic            flush,
    input  logic            hilo_read,
    input  logic            mthi,
    input  logic            mtlo,
    input  logic [XLEN-1:0] wdata,
    output logic [XLEN-1:0] hi,
    output logic [XLEN-1:0] lo,
    output logic            busy,
    output logic            stall,
    output logic            done
);

    localparam int unsigned     CW        = $clog2(XLEN);
    localparam int unsigned     WOFF      = XLEN - HALF;
    localparam logic [XLEN-1:0] HALF_MASK = {{WOFF{1'b0}}, {HALF{1'b1}}};

    muldiv_state_t     state_q, state_d;
    logic              word_q, div_q, neg_q, rneg_q, dz_q;
    logic [CW-1:0]     count_q;
    logic [XLEN-1:0]   mcand_q;
    logic [2*XLEN-1:0] acc_q;
    logic [XLEN-1:0]   hi_q, lo_q;

    // ---------------- issue decode ----------------
    logic              in_word, in_div, in_signed, sign_a, sign_b;
    logic [XLEN-1:0]   a_ext, b_ext, mag_a, mag_b;
    logic [2*XLEN-1:0] acc_init;

    always_comb begin
        in_word   = ~op[2];
        in_div    = op[1];
        in_signed = ~op[0];
        a_ext     = in_word ? (a & HALF_MASK) : a;
        b_ext     = in_word ? (b & HALF_MASK) : b;
        sign_a    = in_signed & (in_word ? a[HALF-1] : a[XLEN-1]);
        sign_b    = in_signed & (in_word ? b[HALF-1] : b[XLEN-1]);
        mag_a     = sign_a ? (-a_ext & (in_word ? HALF_MASK : '1)) : a_ext;
        mag_b     = sign_b ? (-b_ext & (in_word ? HALF_MASK : '1)) : b_ext;
        // Word dividends are pre-shifted so their bits reach the remainder
        // half after HALF left shifts; word products then land at [XLEN+HALF-1:WOFF].
        if (in_div) begin
            acc_init = {{XLEN{1'b0}}, (in_word ? (mag_a << WOFF) : mag_a)};
        end else begin
            acc_init = {{XLEN{1'b0}}, mag_b};
        end
    end

    logic [2*XLEN-1:0] fast_prod;
    logic              fast_path;

`ifdef MULDIV_FAST_MUL_EN
    always_comb begin
        fast_prod = {{XLEN{1'b0}}, mag_a} * {{XLEN{1'b0}}, mag_b};
        if (in_word) begin
            fast_prod = fast_prod << WOFF;
        end
        fast_path = ~in_div;
    end
`else
    always_comb begin
        fast_prod = '0;
        fast_path = 1'b0;
    end
`endif

    // ---------------- iteration ----------------
    logic [2*XLEN-1:0] step_acc;

    muldiv_step #(
        .XLEN(XLEN)
    ) u_step (
        .is_div  (div_q),
        .acc_in  (acc_q),
        .operand (mcand_q),
        .acc_out (step_acc)
    );

    // ---------------- sign fix-up ----------------
    logic [2*XLEN-1:0] prod;
    logic [XLEN-1:0]   quo, rem, res_hi, res_lo, hi_fix, lo_fix;

    always_comb begin
        prod = word_q ? (2*XLEN)'(acc_q[XLEN+HALF-1:WOFF]) : acc_q;
        if (neg_q) begin
            prod = -prod;
        end
        quo = acc_q[XLEN-1:0];
        rem = acc_q[2*XLEN-1:XLEN];
        if (neg_q) begin
            quo = -quo;
        end
        if (rneg_q) begin
            rem = -rem;
        end
        // Divide by zero: remainder already equals the dividend after sign
        // restore; only the quotient needs forcing.
        if (dz_q) begin
            quo = '1;
        end
        if (div_q) begin
            res_hi = rem;
            res_lo = quo;
        end else if (word_q) begin
            res_hi = XLEN'(prod[2*HALF-1:HALF]);
            res_lo = XLEN'(prod[HALF-1:0]);
        end else begin
            res_hi = prod[2*XLEN-1:XLEN];
            res_lo = prod[XLEN-1:0];
        end
        hi_fix = word_q ? {{WOFF{res_hi[HALF-1]}}, res_hi[HALF-1:0]} : res_hi;
        lo_fix = word_q ? {{WOFF{res_lo[HALF-1]}}, res_lo[HALF-1:0]} : res_lo;
    end

    // ---------------- FSM ----------------
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (start && !flush) begin
                    state_d = fast_path ? FIXUP : CALC;
                end
            end
            CALC: begin
                if (flush) begin
                    state_d = IDLE;
                end else if (count_q == '0) begin
                    state_d = FIXUP;
                end
            end
            FIXUP:   state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // ---------------- datapath registers ----------------
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            word_q  <= 1'b0;
            div_q   <= 1'b0;
            neg_q   <= 1'b0;
            rneg_q  <= 1'b0;
            dz_q    <= 1'b0;
            count_q <= '0;
            mcand_q <= '0;
            acc_q   <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start && !flush) begin
                        word_q  <= in_word;
                        div_q   <= in_div;
                        neg_q   <= sign_a ^ sign_b;
                        rneg_q  <= sign_a;
                        dz_q    <= in_div && (mag_b == '0);
                        count_q <= in_word ? CW'(HALF - 1) : CW'(XLEN - 1);
                        mcand_q <= in_div ? mag_b : mag_a;
                        acc_q   <= fast_path ? fast_prod : acc_init;
                    end else if (!start) begin
                        if (mthi) begin
                            hi_q <= wdata;
                        end
                        if (mtlo) begin
                            lo_q <= wdata;
                        end
                    end
                end
                CALC: begin
                    if (!flush) begin
                        acc_q <= step_acc;
                        if (count_q != '0) begin
                            count_q <= count_q - CW'(1);
                        end
                    end
                end
                FIXUP: begin
                    if (!flush) begin
                        hi_q <= hi_fix;
                        lo_q <= lo_fix;
                    end
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        hi    = hi_q;
        lo    = lo_q;
        busy  = (state_q != IDLE);
        stall = busy & (start | hilo_read | mthi | mtlo);
        done  = (state_q == FIXUP) & ~flush;
    end

endmodule

// File: tb/tb_muldiv_ctrl.sv
// tb_muldiv_ctrl: scoreboard bench for muldiv_ctrl. Directed ops push their
// hand-computed HI/LO and write cycle into a queue; a monitor pops and checks
// whenever done pulses. Stall, flush, MTHI/MTLO and async reset are checked
// inline. Honours MULDIV_FAST_MUL_EN for multiply latency.
module tb_muldiv_ctrl;
    import muldiv_pkg::*;

    localparam int unsigned XLEN = 64;
    localparam int unsigned HALF = 32;

    logic            clock = 1'b0;
    logic            reset_n = 1'b1;
    logic            start = 1'b0;
    logic            flush = 1'b0;
    logic            hilo_read = 1'b0;
    logic            mthi = 1'b0;
    logic            mtlo = 1'b0;
    muldiv_op_t      op = MULT;
    logic [XLEN-1:0] a = '0;
    logic [XLEN-1:0] b = '0;
    logic [XLEN-1:0] wdata = '0;
    logic [XLEN-1:0] hi, lo;
    logic            busy, stall, done;

    int unsigned n_checks = 0;
    int unsigned n_fail = 0;
    int unsigned cyc = 0;
    int unsigned next_id = 0;

    typedef struct {
        logic [63:0] hi;
        logic [63:0] lo;
        int unsigned due;
        int unsigned id;
    } exp_t;
    exp_t sb[$];

    muldiv_ctrl #(.XLEN(XLEN), .HALF(HALF)) dut (
        .clock     (clock),
        .reset_n   (reset_n),
        .start     (start),
        .op        (op),
        .a         (a),
        .b         (b),
        .flush     (flush),
        .hilo_read (hilo_read),
        .mthi      (mthi),
        .mtlo      (mtlo),
        .wdata     (wdata),
        .hi        (hi),
        .lo        (lo),
        .busy      (busy),
        .stall     (stall),
        .done      (done)
    );

    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: actual=%h required=%h", nm, act, req);
        end
    endtask

    // Edges from acceptance to the HI/LO write edge (equals busy cycles).
    function automatic int unsigned lat_of(input muldiv_op_t o);
`ifdef MULDIV_FAST_MUL_EN
        if (!o[1]) return 1;
`endif
        return (o[2] ? XLEN : HALF) + 1;
    endfunction

    // Called at the negedge where start is driven.
    task automatic push_exp(input muldiv_op_t o, input logic [63:0] ehi, input logic [63:0] elo);
        exp_t e;
        e.hi  = ehi;
        e.lo  = elo;
        e.due = cyc + 1 + lat_of(o);
        e.id  = next_id;
        next_id++;
        sb.push_back(e);
    endtask

    initial begin : monitor
        exp_t e;
        logic seen;
        forever begin
            @(negedge clock);
            if (reset_n === 1'b1 && done === 1'b1) begin
                seen = done;
                @(posedge clock);
                #1;
                if (sb.size() == 0) begin
                    chk("done_unexpected", 64'(seen), 64'd0);
                end else begin
                    e = sb.pop_front();
                    chk($sformatf("hi#%0d", e.id), hi, e.hi);
                    chk($sformatf("lo#%0d", e.id), lo, e.lo);
                    chk($sformatf("latency#%0d", e.id), 64'(cyc), 64'(e.due));
                end
            end
        end
    end

    task automatic run_op(input muldiv_op_t o, input logic [63:0] va, input logic [63:0] vb,
                          input logic [63:0] ehi, input logic [63:0] elo);
        int unsigned bc;
        int unsigned guard;
        @(negedge clock);
        start = 1'b1;
        op    = o;
        a     = va;
        b     = vb;
        push_exp(o, ehi, elo);
        @(negedge clock);
        start = 1'b0;
        bc    = 0;
        guard = 0;
        while (busy === 1'b1 && guard < 200) begin
            bc++;
            guard++;
            @(negedge clock);
        end
        chk($sformatf("busy_cycles_op%0d", o), 64'(bc), 64'(lat_of(o)));
        @(negedge clock);
    endtask

    initial begin : watchdog
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        n_fail++;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $fatal(1);
    end

    initial begin : stim
        muldiv_op_t  s_op, f_op;
        logic [63:0] s_a, s_b, s_hi, s_lo, f_a, f_b;
        int unsigned guard;
        logic        stall_low;

`ifdef MULDIV_FAST_MUL_EN
        s_op = DDIV;   s_a = 64'hFFFF_FFFF_FFFF_FFF7; s_b = 64'd4;
        s_hi = 64'hFFFF_FFFF_FFFF_FFFF; s_lo = 64'hFFFF_FFFF_FFFF_FFFE;
        f_op = DDIVU;  f_a = 64'd3; f_b = 64'd5;
`else
        s_op = DMULT;  s_a = 64'hFFFF_FFFF_FFFF_FFFE; s_b = 64'd3;
        s_hi = 64'hFFFF_FFFF_FFFF_FFFF; s_lo = 64'hFFFF_FFFF_FFFF_FFFA;
        f_op = DMULTU; f_a = 64'd3; f_b = 64'd5;
`endif

        // Reset state
        #2 reset_n = 1'b0;
        #1;
        chk("reset_hi", hi, 64'd0);
        chk("reset_lo", lo, 64'd0);
        chk("reset_busy", 64'(busy), 64'd0);
        chk("reset_done", 64'(done), 64'd0);
        repeat (2) @(negedge clock);
        reset_n = 1'b1;

        // Directed arithmetic vectors
        run_op(MULT,   64'hFFFF_FFFF_FFFF_FFFD, 64'd7,
                       64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFEB);
        run_op(MULTU,  64'h0000_0000_FFFF_FFFF, 64'h0000_0000_FFFF_FFFF,
                       64'hFFFF_FFFF_FFFF_FFFE, 64'h0000_0000_0000_0001);
        run_op(MULT,   64'h0000_0000_7FFF_FFFF, 64'h0000_0000_7FFF_FFFF,
                       64'h0000_0000_3FFF_FFFF, 64'h0000_0000_0000_0001);
        run_op(MULT,   64'h0000_0000_8000_0000, 64'h0000_0000_8000_0000,
                       64'h0000_0000_4000_0000, 64'h0000_0000_0000_0000);
        run_op(DMULTU, 64'hFFFF_FFFF_FFFF_FFFF, 64'd2,
                       64'h0000_0000_0000_0001, 64'hFFFF_FFFF_FFFF_FFFE);
        run_op(DMULT,  64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF,
                       64'h0000_0000_0000_0000, 64'h8000_0000_0000_0000);
        run_op(DDIVU,  64'd100, 64'd7, 64'd2, 64'd14);
        run_op(DDIV,   64'hFFFF_FFFF_FFFF_FF9C, 64'd7,
                       64'hFFFF_FFFF_FFFF_FFFE, 64'hFFFF_FFFF_FFFF_FFF2);
        run_op(DIVU,   64'h0000_0000_0000_1234, 64'd0,
                       64'h0000_0000_0000_1234, 64'hFFFF_FFFF_FFFF_FFFF);
        run_op(DIV,    64'h0000_0000_8000_0000, 64'h0000_0000_FFFF_FFFF,
                       64'h0000_0000_0000_0000, 64'hFFFF_FFFF_8000_0000);
        run_op(DIV,    64'h1234_5678_FFFF_FFF9, 64'd2,
                       64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFD);
        run_op(DDIV,   64'hFFFF_FFFF_FFFF_FFFB, 64'd0,
                       64'hFFFF_FFFF_FFFF_FFFB, 64'hFFFF_FFFF_FFFF_FFFF);
        run_op(DIVU,   64'hDEAD_BEEF_0000_0010, 64'hFFFF_0000_0000_0003,
                       64'd1, 64'd5);

        // Stall on HI/LO read and on a second start while busy
        @(negedge clock);
        start = 1'b1; op = s_op; a = s_a; b = s_b;
        push_exp(s_op, s_hi, s_lo);
        @(negedge clock);
        start = 1'b0;
        repeat (3) @(negedge clock);
        hilo_read = 1'b1;
        #1 chk("stall_hilo_read", 64'(stall), 64'd1);
        for (int i = 0; i < 2; i++) begin
            @(negedge clock);
            start = 1'b1; op = DDIVU; a = 64'd9; b = 64'd3;
            #1 chk("stall_start_busy", 64'(stall), 64'd1);
        end
        @(negedge clock);
        start = 1'b0;
        guard = 0;
        stall_low = 1'b0;
        #1;
        while (busy === 1'b1 && guard < 200) begin
            if (stall !== 1'b1) stall_low = 1'b1;
            @(negedge clock);
            #1;
            guard++;
        end
        chk("stall_held_while_busy", 64'(stall_low), 64'd0);
        chk("busy_dropped", 64'(busy), 64'd0);
        chk("stall_after_busy", 64'(stall), 64'd0);
        hilo_read = 1'b0;
        repeat (2) @(negedge clock);
        chk("second_start_ignored", 64'(busy), 64'd0);

        // MTHI/MTLO then flush an in-flight op
        @(negedge clock);
        mthi = 1'b1; wdata = 64'hAA;
        @(negedge clock);
        mthi = 1'b0; mtlo = 1'b1; wdata = 64'h0;
        @(negedge clock);
        mtlo = 1'b0;
        #1;
        chk("mthi_write", hi, 64'hAA);
        chk("mtlo_write", lo, 64'h0);
        @(negedge clock);
        start = 1'b1; op = f_op; a = f_a; b = f_b;
        @(negedge clock);
        start = 1'b0;
        repeat (8) @(negedge clock);
        flush = 1'b1;
        #1 chk("flush_busy_before", 64'(busy), 64'd1);
        @(negedge clock);
        flush = 1'b0;
        #1;
        chk("flush_busy", 64'(busy), 64'd0);
        chk("flush_hi_kept", hi, 64'hAA);
        chk("flush_lo_kept", lo, 64'h0);
        repeat (3) @(negedge clock);

        // Flush suppresses an issuing start in IDLE
        start = 1'b1; flush = 1'b1; op = DDIVU; a = 64'd8; b = 64'd2;
        @(negedge clock);
        start = 1'b0; flush = 1'b0;
        #1 chk("flush_idle_suppress", 64'(busy), 64'd0);

        // Load non-zero HI/LO, then reset mid-divide
        run_op(DDIVU, 64'd100, 64'd7, 64'd2, 64'd14);
        @(negedge clock);
        start = 1'b1; op = DDIV; a = 64'hFFFF_FFFF_FFFF_FF9C; b = 64'd7;
        @(negedge clock);
        start = 1'b0;
        repeat (10) @(negedge clock);
        #2 reset_n = 1'b0;
        #1;
        chk("midop_reset_hi", hi, 64'd0);
        chk("midop_reset_lo", lo, 64'd0);
        chk("midop_reset_busy", 64'(busy), 64'd0);
        chk("midop_reset_done", 64'(done), 64'd0);
        repeat (2) @(negedge clock);
        reset_n = 1'b1;
        repeat (4) @(negedge clock);
        chk("scoreboard_empty", 64'(sb.size()), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
